// File: rtl/fetch_addr_unit.sv
// PC / IR / memory-address sequencer for the multicycle CPU.
// Drives a single shared memory port for instruction fetches and one data access per EXEC.
module fetch_addr_unit #(
    parameter int unsigned          ADDR_W   = 9,
    parameter int unsigned          INS_W    = 16,
    parameter int unsigned          OFF_W    = 8,
    parameter logic [ADDR_W-1:0]    RESET_PC = '0,
    parameter int unsigned          MAX_WAIT = 15
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [INS_W-1:0]  mem_rdata,
    input  logic              mem_ready,
    output logic [1:0]        mem_cmd,
    output logic [ADDR_W-1:0] mem_addr,
    input  logic              data_req,
    input  logic              data_we,
    input  logic [ADDR_W-1:0] data_addr,
    input  logic              ins_done,
    input  logic              branch_en,
    input  logic              branch_rel,
    input  logic [ADDR_W-1:0] branch_target,
    input  logic [OFF_W-1:0]  branch_off,
    input  logic              halt_req,
    output logic [ADDR_W-1:0] pc,
    output logic [INS_W-1:0]  ir,
    output logic              ins_valid,
    output logic [INS_W-1:0]  rd_data,
    output logic              rd_valid,
    output logic              halted,
    output logic              fault
);

    localparam logic [1:0] CMD_NONE  = 2'b00;
    localparam logic [1:0] CMD_READ  = 2'b01;
    localparam logic [1:0] CMD_WRITE = 2'b10;
    localparam int unsigned WC_W = (MAX_WAIT > 0) ? $clog2(MAX_WAIT + 1) : 1;

    typedef enum logic [2:0] {
        S_RST   = 3'd0,
        S_FETCH = 3'd1,
        S_EXEC  = 3'd2,
        S_DATA  = 3'd3,
        S_HALT  = 3'd4,
        S_FAULT = 3'd5
    } state_t;

    state_t            state, state_nx;
    logic [ADDR_W-1:0] da;
    logic              we_q;
    logic [WC_W-1:0]   wait_cnt;
    logic [ADDR_W-1:0] off_sext;
    logic              timeout;

    assign off_sext = ADDR_W'($signed(branch_off));

    // Timeout fires on the not-ready cycle that would push the count past MAX_WAIT.
    assign timeout = (MAX_WAIT != 0) && (wait_cnt == WC_W'(MAX_WAIT)) && !mem_ready;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) state <= S_RST;
        else        state <= state_nx;
    end

    always_comb begin
        state_nx = state;
        case (state)
            S_RST:   state_nx = S_FETCH;
            S_FETCH: begin
                if (mem_ready)    state_nx = S_EXEC;
                else if (timeout) state_nx = S_FAULT;
            end
            S_EXEC: begin
                if (halt_req)      state_nx = S_HALT;
                else if (data_req) state_nx = S_DATA;
                else if (ins_done) state_nx = S_FETCH;
            end
            S_DATA: begin
                if (mem_ready)    state_nx = S_EXEC;
                else if (timeout) state_nx = S_FAULT;
            end
            S_HALT:  state_nx = S_HALT;
            S_FAULT: state_nx = S_FAULT;
            default: state_nx = S_RST;
        endcase
    end

    always_comb begin
        mem_cmd   = CMD_NONE;
        mem_addr  = '0;
        ins_valid = 1'b0;
        halted    = 1'b0;
        fault     = 1'b0;
        case (state)
            S_FETCH: begin
                mem_cmd  = CMD_READ;
                mem_addr = pc;
            end
            S_EXEC: begin
                mem_addr  = pc;
                ins_valid = 1'b1;
            end
            S_DATA: begin
                mem_cmd  = we_q ? CMD_WRITE : CMD_READ;
                mem_addr = da;
            end
            S_HALT:  halted = 1'b1;
            S_FAULT: fault  = 1'b1;
            default: ;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            pc       <= RESET_PC;
            ir       <= '0;
            rd_data  <= '0;
            rd_valid <= 1'b0;
            da       <= '0;
            we_q     <= 1'b0;
            wait_cnt <= '0;
        end else begin
            rd_valid <= 1'b0;
            case (state)
                S_FETCH: begin
                    if (mem_ready) begin
                        ir       <= mem_rdata;
                        pc       <= pc + 1'b1;
                        wait_cnt <= '0;
                    end else begin
                        wait_cnt <= wait_cnt + 1'b1;
                    end
                end
                S_EXEC: begin
                    // halt and data access both mask the branch/next-instruction inputs
                    if (halt_req) begin
                        wait_cnt <= '0;
                    end else if (data_req) begin
                        da       <= data_addr;
                        we_q     <= data_we;
                        wait_cnt <= '0;
                    end else if (ins_done) begin
                        wait_cnt <= '0;
                        if (branch_en) pc <= branch_rel ? (pc + off_sext) : branch_target;
                    end
                end
                S_DATA: begin
                    if (mem_ready) begin
                        wait_cnt <= '0;
                        if (!we_q) begin
                            rd_data  <= mem_rdata;
                            rd_valid <= 1'b1;
                        end
                    end else begin
                        wait_cnt <= wait_cnt + 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule
